// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle PC sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        TRAP  = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        IMEM_TO  = 2'd2,
        DMEM_TO  = 2'd3
    } trap_cause_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_sequencer_wait_timer.sv
// Request wait timer shared by the fetch and data-memory phases.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (busy && !ack) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Fires in the MAX_WAIT-th unacknowledged request cycle; an ack in that cycle wins.
    assign expired = busy && !ack && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer owning the PC, with sticky trap and retire counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] currPC,
    output logic [31:0] PC_plus4,
    input  logic [31:0] branch_PC,
    input  logic        takeBranch,
    input  logic        is_mem,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_pc,
    output logic [31:0] instret,
    output logic [31:0] redirect_cnt
);

    seq_state_t  r_state;
    trap_cause_t r_trap_cause;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_next_pc;
    logic        r_tb_q;
    logic [31:0] r_trap_pc;
    logic [31:0] r_instret;
    logic [31:0] r_redirect;

    logic w_in_fetch;
    logic w_in_mem;
    logic w_clr;
    logic w_busy;
    logic w_ack;
    logic w_expired;

    assign w_in_fetch = (r_state == FETCH);
    assign w_in_mem   = (r_state == MEM);

    // Requests are gated by rst so an outstanding request drops in the reset cycle itself.
    assign imem_req = w_in_fetch && !rst;
    assign dmem_req = w_in_mem && !rst;

    // Holding the timer clear outside FETCH/MEM gives a zero count on every entry.
    assign w_clr  = !(w_in_fetch || w_in_mem);
    assign w_busy = imem_req || dmem_req;
    assign w_ack  = w_in_fetch ? imem_ack : dmem_ack;

    wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .busy   (w_busy),
        .ack    (w_ack),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_next_pc    <= RESET_PC;
            r_tb_q       <= 1'b0;
            r_trap_cause <= NONE;
            r_trap_pc    <= '0;
            r_instret    <= '0;
            r_redirect   <= '0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= EXEC;
                    end else if (w_expired) begin
                        r_trap_cause <= IMEM_TO;
                        r_trap_pc    <= r_pc;
                        r_state      <= TRAP;
                    end
                end
                EXEC: begin
                    r_next_pc <= branch_PC;
                    r_tb_q    <= takeBranch;
                    if (branch_PC[1:0] != 2'b00) begin
                        r_trap_cause <= MISALIGN;
                        r_trap_pc    <= r_pc;
                        r_state      <= TRAP;
                    end else if (is_mem) begin
                        r_state <= MEM;
                    end else begin
                        r_state <= WB;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        r_state <= WB;
                    end else if (w_expired) begin
                        r_trap_cause <= DMEM_TO;
                        r_trap_pc    <= r_pc;
                        r_state      <= TRAP;
                    end
                end
                WB: begin
                    r_pc      <= r_next_pc;
                    r_instret <= r_instret + 32'd1;
                    if (r_tb_q) begin
                        r_redirect <= r_redirect + 32'd1;
                    end
                    r_state <= FETCH;
                end
                TRAP: begin
                    r_state <= TRAP;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_addr    = r_pc;
    assign currPC       = r_pc;
    assign PC_plus4     = r_pc + 32'd4;
    assign instr        = r_instr;
    assign reg_we       = (r_state == WB);
    assign retire       = (r_state == WB);
    assign trap         = (r_state == TRAP);
    assign trap_cause   = r_trap_cause;
    assign trap_pc      = r_trap_pc;
    assign instret      = r_instret;
    assign redirect_cnt = r_redirect;

endmodule
